seq_signed_divider: RTL and testbench
=====================================

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when busy is low.
REQ-005 The block SHALL have port X, input, WIDTH bits, signed: dividend.
REQ-006 The block SHALL have port Y, input, WIDTH bits, signed: divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: division in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port Q, output, WIDTH bits, signed: quotient.
REQ-010 The block SHALL have port R, output, WIDTH bits, signed: remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the last result had Y == 0.
REQ-012 The block SHALL have port ovf, output, 1 bit: the last result overflowed (see REQ-026).

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX and DONE; the block SHALL reset into IDLE.
REQ-014 IDLE with start high SHALL capture X, Y, their signs and magnitudes, clear the partial remainder, load the iteration counter with WIDTH-1, and go to CALC.
REQ-015 CALC SHALL perform one restoring step per cycle: shift the remainder left taking the next dividend MSB; subtract |Y| if the result is non-negative; shift the quotient bit in.
REQ-016 CALC SHALL run exactly WIDTH cycles, then go to FIX; the counter SHALL decrement each CALC cycle and never wrap.
REQ-017 FIX SHALL apply signs: negate the quotient if sign(X) differs from sign(Y); negate the remainder if X is negative. It SHALL then go to DONE.
REQ-018 Results SHALL truncate toward zero, with |R| < |Y| and sign(R) = sign(X), or R = 0.
REQ-019 DONE SHALL drive done high for exactly one cycle and return to IDLE.
REQ-020 Latency SHALL be fixed at WIDTH+2 cycles: start sampled at edge N gives done high after edge N+WIDTH+2. This holds for every operand value, including Y = 0.
REQ-021 busy SHALL be high in CALC, FIX and DONE, and low in IDLE.
REQ-022 start SHALL be ignored while busy is high. A start in the cycle after done is accepted.
REQ-023 Q, R, div_by_zero and ovf SHALL hold their values from done until the FIX state of the next operation.
REQ-024 X and Y SHALL be sampled only at acceptance; later input changes SHALL NOT affect the result.
REQ-025 Y == 0 SHALL give Q = all ones, R = X and div_by_zero = 1; otherwise div_by_zero SHALL be 0.
REQ-026 X = -2^(WIDTH-1) with Y = -1 SHALL give Q = -2^(WIDTH-1) and R = 0.

Reset
REQ-027 rst high SHALL force IDLE and set busy, done, Q, R, div_by_zero and ovf to 0 at the next edge.
REQ-028 rst SHALL take priority over start and over any state, including mid-CALC; a partial operation SHALL be discarded.
REQ-029 The first start accepted after rst falls SHALL be the one sampled at the first edge with rst low.

Configuration
REQ-030 With macro SEQ_DIV_OVF_DETECT_EN defined, ovf SHALL be set to 1 for the REQ-026 case and to 0 otherwise, updated in FIX.
REQ-031 Without SEQ_DIV_OVF_DETECT_EN, the ovf port SHALL still exist, be tied to 0, and need no detection logic; all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package div_pkg SHALL hold the default WIDTH constant, the FSM state typedef (IDLE, CALC, FIX, DONE) and a localparam for the minimum signed value.
REQ-033 One combinational sub-module div_step SHALL implement a single restoring iteration (remainder in, dividend bit in, |Y| in -> new remainder, quotient bit). It SHALL be instantiated once, inside seq_signed_divider.

Verification
REQ-034 X=100, Y=7, start -> done after 34 cycles, Q=14, R=2, div_by_zero=0.
REQ-035 X=-100, Y=7 -> Q=-14 (0xFFFFFFF2), R=-2. X=100, Y=-7 -> Q=-14, R=2.
REQ-036 X=7, Y=0 -> Q=0xFFFFFFFF, R=7, div_by_zero=1, done after 34 cycles.
REQ-037 X=0x80000000, Y=0xFFFFFFFF -> Q=0x80000000, R=0; ovf=1 with SEQ_DIV_OVF_DETECT_EN, ovf=0 without.
REQ-038 Start X=50, Y=5, then start X=9, Y=3 during CALC -> second start ignored, Q=10, R=0.
REQ-039 rst pulsed at CALC cycle 10 -> all outputs 0 and state IDLE; a new start X=9, Y=3 -> Q=3, R=0 after 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the default width, the FSM state type and the signed minimum.
package div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [DEF_WIDTH-1:0] MIN_SIGNED =
    {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// Shifts in a dividend bit and subtracts the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign sh   = {rem_i, bit_i};
  assign diff = sh - {1'b0, dvs_i};

  // Keep the difference only when the trial subtraction stays non-negative.
  always_comb begin
    q_o   = ~diff[WIDTH];
    rem_o = sh[WIDTH-1:0];
    if (!diff[WIDTH]) rem_o = diff[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Fixed-latency signed restoring divider, WIDTH+2 cycles per result.
// Define SEQ_DIV_OVF_DETECT_EN to flag MIN / -1 on the ovf port.
import div_pkg::*;

module seq_signed_divider #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] Q,
  output logic signed [WIDTH-1:0] R,
  output logic                    div_by_zero,
  output logic                    ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] x_q;
  logic             xs_q;
  logic             ys_q;

  logic [WIDTH-1:0] xmag_d;
  logic [WIDTH-1:0] ymag_d;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;

  assign xmag_d = X[WIDTH-1] ? (~X + 1'b1) : X;
  assign ymag_d = Y[WIDTH-1] ? (~Y + 1'b1) : Y;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

`ifdef SEQ_DIV_OVF_DETECT_EN
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_case;
  assign ovf_case = (x_q == MINV) && ys_q &&
                    (dvs_q == {{(WIDTH-1){1'b0}}, 1'b1});
`else
  assign ovf = 1'b0;
`endif

  // Control FSM with the datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      x_q         <= '0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_OVF_DETECT_EN
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= X;
            xs_q    <= X[WIDTH-1];
            ys_q    <= Y[WIDTH-1];
            dvd_q   <= xmag_d;
            dvs_q   <= ymag_d;
            rem_q   <= '0;
            cnt_q   <= CNT_INIT;
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
          if (cnt_q == '0) state_q <= FIX;
          else cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          if (dvs_q == '0) begin
            Q           <= '1;
            R           <= x_q;
            div_by_zero <= 1'b1;
          end else begin
            Q           <= (xs_q ^ ys_q) ? (~dvd_q + 1'b1) : dvd_q;
            R           <= xs_q ? (~rem_q + 1'b1) : rem_q;
            div_by_zero <= 1'b0;
          end
`ifdef SEQ_DIV_OVF_DETECT_EN
          ovf     <= ovf_case;
`endif
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH = 32).
// Table vectors, hand corner sequences and randomized ops vs a model.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        div_by_zero;
  logic        ovf;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .X           (X),
    .Y           (Y),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    logic [31:0] r;
    logic        d;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [31:0] x,
                                   input logic [31:0] y);
`ifdef SEQ_DIV_OVF_DETECT_EN
    return (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
`else
    return 1'b0 & x[0] & y[0];
`endif
  endfunction

  // Reference: plain 64-bit signed arithmetic plus the two special rules.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic d);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    d  = (y == 0);
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else begin
      q = 32'(sx / sy);
      r = 32'(sx % sy);
    end
  endtask

  // Issue one op; optionally poke a competing start and change inputs.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input bit poke,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic d, output logic o, output int lat);
    @(negedge clk);
    X = x;
    Y = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    X = $urandom;
    Y = $urandom;
    lat = 0;
    do begin
      if (poke && lat == 5) begin
        start = 1'b1;
        X = 32'd9;
        Y = 32'd3;
      end
      if (poke && lat == 9) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 100);
    q = Q;
    r = R;
    d = div_by_zero;
    o = ovf;
  endtask

  initial begin
    logic [31:0] q, r, eq, er, x, y;
    logic        d, o, ed;
    int          lat;

    tbl[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0};
    tbl[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0};
    tbl[4]  = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1};
    tbl[5]  = '{32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
    tbl[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
    tbl[7]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    tbl[8]  = '{32'd1, 32'h8000_0000, 32'd0, 32'd1, 1'b0};
    tbl[9]  = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0};
    tbl[10] = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0};
    tbl[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0};

    rst = 1'b1;
    start = 1'b1;
    X = 32'd55;
    Y = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_Q", Q, 32'd0);
    chk("reset_R", R, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].x, tbl[i].y, 1'b0, q, r, d, o, lat);
      chk($sformatf("tbl%0d_Q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_R", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), {31'd0, d}, {31'd0, tbl[i].d});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, o},
          {31'd0, exp_ovf(tbl[i].x, tbl[i].y)});
      chk($sformatf("tbl%0d_lat", i), lat, 32'd34);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("tbl%0d_holdQ", i), Q, tbl[i].q);
    end

    do_op(32'd50, 32'd5, 1'b1, q, r, d, o, lat);
    chk("ign_Q", q, 32'd10);
    chk("ign_R", r, 32'd0);
    chk("ign_lat", lat, 32'd34);
    @(posedge clk);
    #1;
    chk("ign_idle", {31'd0, busy}, 32'd0);

    @(negedge clk);
    X = 32'd123;
    Y = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_Q", Q, 32'd0);
    chk("mid_rst_R", R, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) lat++;
    end
    chk("mid_rst_quiet", lat, 32'd0);
    do_op(32'd9, 32'd3, 1'b0, q, r, d, o, lat);
    chk("post_rst_Q", q, 32'd3);
    chk("post_rst_R", r, 32'd0);
    chk("post_rst_lat", lat, 32'd34);

    for (int i = 0; i < 200; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'($urandom_range(0, 20));
        1: y = -32'($urandom_range(1, 20));
        2: y = 32'd0;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      if (i == 100) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      ref_div(x, y, eq, er, ed);
      do_op(x, y, 1'b0, q, r, d, o, lat);
      chk($sformatf("rnd%0d_Q x=%h y=%h", i, x, y), q, eq);
      chk($sformatf("rnd%0d_R x=%h y=%h", i, x, y), r, er);
      chk($sformatf("rnd%0d_dbz", i), {31'd0, d}, {31'd0, ed});
      chk($sformatf("rnd%0d_ovf", i), {31'd0, o}, {31'd0, exp_ovf(x, y)});
      chk($sformatf("rnd%0d_lat", i), lat, 32'd34);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
